// File: rtl/lcd_text_sequencer.sv
// lcd_text_sequencer: shadows a 16x2 text screen written by the CPU and
// replays it to an HD44780-style LCD slave. It runs the power-up delay and the
// init command list, then does a full refresh whenever the shadow changes. Each
// LCD access has a stretched setup/strobe/hold shape and is followed by
// busy-flag polling.
module lcd_text_sequencer #(
  parameter int POWERUP_CYCLES = 750000,
  parameter int SETUP_CYCLES   = 3,
  parameter int E_CYCLES       = 12,
  parameter int HOLD_CYCLES    = 3
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [4:0] s_address,
  input  logic       s_write,
  input  logic [7:0] s_writedata,
  input  logic       s_read,
  output logic [7:0] s_readdata,
  output logic [1:0] m_address,
  output logic       m_begintransfer,
  output logic       m_read,
  output logic       m_write,
  output logic [7:0] m_writedata,
  input  logic [7:0] m_readdata
);

  localparam int MAX_A = (SETUP_CYCLES > E_CYCLES) ? SETUP_CYCLES : E_CYCLES;
  localparam int MAX_B = (MAX_A > HOLD_CYCLES) ? MAX_A : HOLD_CYCLES;
  localparam int MAX_C = (MAX_B > POWERUP_CYCLES) ? MAX_B : POWERUP_CYCLES;
  localparam int CNT_W = $clog2(MAX_C + 1);

  localparam logic [CNT_W-1:0] CNT_ZERO    = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE     = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] PWR_LAST    = CNT_W'(POWERUP_CYCLES - 1);
  localparam logic [CNT_W-1:0] SETUP_LAST  = CNT_W'(SETUP_CYCLES - 1);
  localparam logic [CNT_W-1:0] STROBE_LAST = CNT_W'(E_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_CYCLES - 1);

  // Access codes on m_address: {RS, RW}
  localparam logic [1:0] CODE_CMD  = 2'b00;
  localparam logic [1:0] CODE_BUSY = 2'b01;
  localparam logic [1:0] CODE_DATA = 2'b10;

  typedef enum logic [2:0] {
    ST_PWRUP = 3'd0,
    ST_INIT  = 3'd1,
    ST_IDLE  = 3'd2,
    ST_ADDR1 = 3'd3,
    ST_LINE1 = 3'd4,
    ST_ADDR2 = 3'd5,
    ST_LINE2 = 3'd6
  } main_e;

  typedef enum logic [1:0] {
    ACC_SETUP  = 2'd0,
    ACC_STROBE = 2'd1,
    ACC_HOLD   = 2'd2
  } acc_e;

  typedef enum logic {
    STEP_WR   = 1'b0,
    STEP_POLL = 1'b1
  } step_e;

  main_e            main_r, main_s;
  acc_e             acc_r, acc_s;
  step_e            step_r, step_s;
  logic [CNT_W-1:0] cnt_r, cnt_s;
  logic [4:0]       idx_r, idx_s;
  logic             busy_r, busy_s;
  logic             dirty_r, dirty_s;
  logic             start_s;
  logic             active_s;
  logic [1:0]       acc_addr_s;
  logic [7:0]       acc_data_s;
  logic [7:0]       buf_r [32];
  logic             unused_s;

  // Only the busy flag of the LCD readback is meaningful here
  assign unused_s = ^m_readdata[6:0];

  // Init command list: function set, display on, clear, entry mode
  function automatic logic [7:0] init_cmd(input logic [1:0] n);
    logic [7:0] c;
    case (n)
      2'd0:    c = 8'h38;
      2'd1:    c = 8'h0C;
      2'd2:    c = 8'h01;
      2'd3:    c = 8'h06;
      default: c = 8'h38;
    endcase
    return c;
  endfunction

  // State registers for the main sequence and access engine
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      main_r <= ST_PWRUP;
      acc_r  <= ACC_SETUP;
      step_r <= STEP_WR;
      cnt_r  <= CNT_ZERO;
      idx_r  <= 5'd0;
      busy_r <= 1'b0;
    end else begin
      main_r <= main_s;
      acc_r  <= acc_s;
      step_r <= step_s;
      cnt_r  <= cnt_s;
      idx_r  <= idx_s;
      busy_r <= busy_s;
    end
  end

  // Next-state: power-up wait, idle, and the setup/strobe/hold/poll engine
  always_comb begin
    main_s  = main_r;
    acc_s   = acc_r;
    step_s  = step_r;
    cnt_s   = cnt_r + CNT_ONE;
    idx_s   = idx_r;
    busy_s  = busy_r;
    start_s = 1'b0;
    case (main_r)
      ST_PWRUP: begin
        if (cnt_r == PWR_LAST) begin
          main_s  = ST_INIT;
          idx_s   = 5'd0;
          step_s  = STEP_WR;
          acc_s   = ACC_SETUP;
          cnt_s   = CNT_ZERO;
          start_s = 1'b1;
        end else begin
          main_s = ST_PWRUP;
        end
      end
      ST_IDLE: begin
        cnt_s = CNT_ZERO;
        if (dirty_r) begin
          main_s  = ST_ADDR1;
          idx_s   = 5'd0;
          step_s  = STEP_WR;
          acc_s   = ACC_SETUP;
          start_s = 1'b1;
        end else begin
          main_s = ST_IDLE;
        end
      end
      default: begin
        case (acc_r)
          ACC_SETUP: begin
            if (cnt_r == SETUP_LAST) begin
              acc_s = ACC_STROBE;
              cnt_s = CNT_ZERO;
            end else begin
              acc_s = ACC_SETUP;
            end
          end
          ACC_STROBE: begin
            if (cnt_r == STROBE_LAST) begin
              acc_s = ACC_HOLD;
              cnt_s = CNT_ZERO;
              if (step_r == STEP_POLL) begin
                busy_s = m_readdata[7];
              end else begin
                busy_s = 1'b0;
              end
            end else begin
              acc_s = ACC_STROBE;
            end
          end
          ACC_HOLD: begin
            if (cnt_r == HOLD_LAST) begin
              acc_s   = ACC_SETUP;
              cnt_s   = CNT_ZERO;
              start_s = 1'b1;
              if (step_r == STEP_WR) begin
                step_s = STEP_POLL;
              end else if (busy_r) begin
                step_s = STEP_POLL;
              end else begin
                step_s = STEP_WR;
                case (main_r)
                  ST_INIT: begin
                    if (idx_r == 5'd3) begin
                      main_s  = ST_IDLE;
                      idx_s   = 5'd0;
                      start_s = 1'b0;
                    end else begin
                      idx_s = idx_r + 5'd1;
                    end
                  end
                  ST_ADDR1: begin
                    main_s = ST_LINE1;
                    idx_s  = 5'd0;
                  end
                  ST_LINE1: begin
                    idx_s = idx_r + 5'd1;
                    if (idx_r == 5'd15) begin
                      main_s = ST_ADDR2;
                    end else begin
                      main_s = ST_LINE1;
                    end
                  end
                  ST_ADDR2: begin
                    main_s = ST_LINE2;
                  end
                  ST_LINE2: begin
                    idx_s = idx_r + 5'd1;
                    if (idx_r == 5'd31) begin
                      main_s  = ST_IDLE;
                      start_s = 1'b0;
                    end else begin
                      main_s = ST_LINE2;
                    end
                  end
                  default: begin
                    main_s  = ST_IDLE;
                    start_s = 1'b0;
                  end
                endcase
              end
            end else begin
              acc_s = ACC_HOLD;
            end
          end
          default: begin
            acc_s = ACC_SETUP;
            cnt_s = CNT_ZERO;
          end
        endcase
      end
    endcase
  end

  // An LCD access is in progress whenever the sequence is neither waiting nor idle
  assign active_s = (main_s != ST_PWRUP) && (main_s != ST_IDLE);

  // Address/data of the access about to start, latched once so it stays constant
  always_comb begin
    acc_addr_s = CODE_CMD;
    acc_data_s = 8'h00;
    if (step_s == STEP_POLL) begin
      acc_addr_s = CODE_BUSY;
      acc_data_s = 8'h00;
    end else begin
      case (main_s)
        ST_INIT: begin
          acc_addr_s = CODE_CMD;
          acc_data_s = init_cmd(idx_s[1:0]);
        end
        ST_ADDR1: begin
          acc_addr_s = CODE_CMD;
          acc_data_s = 8'h80;
        end
        ST_ADDR2: begin
          acc_addr_s = CODE_CMD;
          acc_data_s = 8'hC0;
        end
        ST_LINE1, ST_LINE2: begin
          acc_addr_s = CODE_DATA;
          acc_data_s = buf_r[idx_s];
        end
        default: begin
          acc_addr_s = CODE_CMD;
          acc_data_s = 8'h00;
        end
      endcase
    end
  end

  // Master outputs registered from the next state so they line up with the phases
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_address       <= 2'b00;
      m_writedata     <= 8'h00;
      m_read          <= 1'b0;
      m_write         <= 1'b0;
      m_begintransfer <= 1'b0;
    end else begin
      m_read          <= active_s && (acc_s == ACC_STROBE) && (step_s == STEP_POLL);
      m_write         <= active_s && (acc_s == ACC_STROBE) && (step_s == STEP_WR);
      m_begintransfer <= active_s && (acc_s == ACC_STROBE) && (cnt_s == CNT_ZERO);
      if (start_s) begin
        m_address   <= acc_addr_s;
        m_writedata <= acc_data_s;
      end else if (!active_s) begin
        m_address   <= 2'b00;
        m_writedata <= 8'h00;
      end else begin
        m_address   <= m_address;
        m_writedata <= m_writedata;
      end
    end
  end

  // Dirty flag: a CPU write always wins over the clear on leaving idle
  always_comb begin
    dirty_s = dirty_r;
    if (s_write) begin
      dirty_s = 1'b1;
    end else if (main_r == ST_IDLE) begin
      dirty_s = 1'b0;
    end else begin
      dirty_s = dirty_r;
    end
  end

  // Dirty register and the space-filled shadow character buffer
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dirty_r <= 1'b1;
      for (int i = 0; i < 32; i++) begin
        buf_r[i] <= 8'h20;
      end
    end else begin
      dirty_r <= dirty_s;
      if (s_write) begin
        buf_r[s_address] <= s_writedata;
      end
    end
  end

  // CPU status register, refreshed on each status read
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s_readdata <= 8'h00;
    end else if (s_read) begin
      s_readdata <= {6'b000000, dirty_r, (main_r != ST_IDLE)};
    end else begin
      s_readdata <= s_readdata;
    end
  end

endmodule

// File: tb/tb_lcd_text_sequencer.sv
// Bench for lcd_text_sequencer: a scoreboard of expected LCD accesses built from
// the screen contents, a busy-flag responder, and an access-shape monitor.
module tb_lcd_text_sequencer;

  localparam int PWR  = 20;
  localparam int SETC = 3;
  localparam int ECYC = 12;
  localparam int HOLD = 3;

  logic       clk;
  logic       reset_n;
  logic [4:0] s_address;
  logic       s_write;
  logic [7:0] s_writedata;
  logic       s_read;
  logic [7:0] s_readdata;
  logic [1:0] m_address;
  logic       m_begintransfer;
  logic       m_read;
  logic       m_write;
  logic [7:0] m_writedata;
  logic [7:0] m_readdata;

  lcd_text_sequencer #(
    .POWERUP_CYCLES(PWR),
    .SETUP_CYCLES(SETC),
    .E_CYCLES(ECYC),
    .HOLD_CYCLES(HOLD)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .s_address(s_address),
    .s_write(s_write),
    .s_writedata(s_writedata),
    .s_read(s_read),
    .s_readdata(s_readdata),
    .m_address(m_address),
    .m_begintransfer(m_begintransfer),
    .m_read(m_read),
    .m_write(m_write),
    .m_writedata(m_writedata),
    .m_readdata(m_readdata)
  );

  // Expected access: busy read, or write of a literal / of a screen cell
  typedef struct packed {
    logic       rd;
    logic [1:0] addr;
    logic       is_idx;
    logic [7:0] val;
  } exp_t;

  exp_t       exp_q[$];
  int         busy_q[$];
  logic [7:0] model_buf [32];
  int         compared   = 0;
  int         mismatched = 0;
  int         wr_seen    = 0;

  // Free-running clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic push_wr(input logic [1:0] a, input logic is_idx, input logic [7:0] v, input int nb);
    exp_t e;
    e.rd = 1'b0; e.addr = a; e.is_idx = is_idx; e.val = v;
    exp_q.push_back(e);
    busy_q.push_back(nb);
    for (int i = 0; i <= nb; i++) begin
      e.rd = 1'b1; e.addr = 2'b01; e.is_idx = 1'b0; e.val = 8'h00;
      exp_q.push_back(e);
    end
  endtask

  function automatic int rb();
    return int'($urandom_range(0, 2));
  endfunction

  task automatic push_init();
    push_wr(2'b00, 1'b0, 8'h38, rb());
    push_wr(2'b00, 1'b0, 8'h0C, rb());
    push_wr(2'b00, 1'b0, 8'h01, 3);
    push_wr(2'b00, 1'b0, 8'h06, rb());
  endtask

  task automatic push_refresh();
    push_wr(2'b00, 1'b0, 8'h80, rb());
    for (int i = 0; i < 16; i++) push_wr(2'b10, 1'b1, 8'(i), rb());
    push_wr(2'b00, 1'b0, 8'hC0, rb());
    for (int i = 16; i < 32; i++) push_wr(2'b10, 1'b1, 8'(i), rb());
  endtask

  task automatic cpu_write(input logic [4:0] a, input logic [7:0] d);
    @(negedge clk);
    s_address = a; s_writedata = d; s_write = 1'b1;
    model_buf[a] = d;
    @(negedge clk);
    s_write = 1'b0;
  endtask

  task automatic status_check(input string name, input logic [7:0] req);
    @(negedge clk);
    s_read = 1'b1;
    @(negedge clk);
    s_read = 1'b0;
    check(name, {24'h0, s_readdata}, {24'h0, req});
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 20000) begin
      @(negedge clk);
      n++;
    end
    repeat (40) @(negedge clk);
    check(name, exp_q.size(), 0);
  endtask

  // Busy-flag model: after each write, report busy for the queued number of reads
  initial begin : responder
    int  busy_left;
    bit  prev_rd;
    busy_left  = 0;
    prev_rd    = 1'b0;
    m_readdata = 8'h00;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        busy_left = 0;
        prev_rd   = 1'b0;
      end else begin
        if (m_begintransfer && m_write) busy_left = (busy_q.size() > 0) ? busy_q.pop_front() : 0;
        if (prev_rd && !m_read && busy_left > 0) busy_left = busy_left - 1;
        prev_rd = m_read;
      end
      m_readdata = {(busy_left > 0), 7'($urandom_range(0, 127))};
    end
  end

  // Monitor: pops the scoreboard at each strobe start and checks the access shape
  initial begin : monitor
    logic [9:0] h1, h2, h3, cur, smp;
    int         scnt, hcnt;
    bit         in_strobe, in_hold, tok;
    exp_t       e;
    logic [7:0] want;
    h1 = '0; h2 = '0; h3 = '0; cur = '0;
    scnt = 0; hcnt = 0; in_strobe = 1'b0; in_hold = 1'b0; tok = 1'b1;
    forever begin
      @(negedge clk);
      smp = {m_address, m_writedata};
      if (!reset_n) begin
        in_strobe = 1'b0;
        in_hold   = 1'b0;
      end else begin
        if (m_begintransfer) begin
          tok = (h1 == smp) && (h2 == smp) && (h3 == smp) && (m_read ^ m_write) && !in_strobe && !in_hold;
          cur = smp; in_strobe = 1'b1; scnt = 0;
          if (m_write) wr_seen++;
          if (exp_q.size() == 0) begin
            compared++;
            mismatched++;
            $display("FAIL access: unexpected access rd=%0b addr=%0b data=%0h at %0t", m_read, m_address, m_writedata, $time);
          end else begin
            e = exp_q.pop_front();
            want = e.is_idx ? model_buf[e.val[4:0]] : e.val;
            check("access", {21'h0, m_read, m_address, (m_read ? 8'h00 : m_writedata)},
                  {21'h0, e.rd, e.addr, (e.rd ? 8'h00 : want)});
          end
        end
        if (in_strobe) begin
          if (m_read || m_write) begin
            scnt++;
            if (smp != cur || (m_read && m_write) || (m_begintransfer && scnt > 1)) tok = 1'b0;
          end else begin
            in_strobe = 1'b0;
            in_hold   = 1'b1;
            hcnt      = 0;
          end
        end
        if (in_hold) begin
          if (smp != cur || m_begintransfer) tok = 1'b0;
          hcnt++;
          if (hcnt == HOLD) begin
            in_hold = 1'b0;
            check("strobe_len", scnt, ECYC);
            check("access_stable", {31'h0, tok}, 32'd1);
          end
        end
      end
      h3 = h2; h2 = h1; h1 = smp;
    end
  end

  // Stimulus
  initial begin : stimulus
    int base, n;
    reset_n = 1'b0; s_address = 5'd0; s_write = 1'b0; s_writedata = 8'h00; s_read = 1'b0;
    for (int i = 0; i < 32; i++) model_buf[i] = 8'h20;
    @(posedge clk);
    #1;
    check("reset_outputs", {11'h0, m_address, m_begintransfer, m_read, m_write, m_writedata, s_readdata}, 32'h0);
    push_init();
    push_refresh();
    @(negedge clk);
    reset_n = 1'b1;
    status_check("status_pwrup", 8'h03);
    wait_drain("drain_init");
    status_check("status_idle", 8'h00);

    // Single writes in idle, each followed by exactly one refresh
    for (int r = 0; r < 3; r++) begin
      cpu_write((r == 0) ? 5'd17 : 5'($urandom_range(0, 31)),
                (r == 0) ? 8'h41 : 8'($urandom_range(33, 126)));
      push_refresh();
      wait_drain("drain_refresh");
      status_check("status_after_refresh", 8'h00);
    end

    // Write during line 1 of a refresh forces one more complete refresh
    base = wr_seen;
    cpu_write(5'($urandom_range(0, 15)), 8'($urandom_range(33, 126)));
    push_refresh();
    repeat (200) @(negedge clk);
    cpu_write(5'(16 + $urandom_range(0, 15)), 8'($urandom_range(33, 126)));
    status_check("status_dirty_mid", 8'h03);
    push_refresh();
    wait_drain("drain_double");
    check("double_refresh_writes", wr_seen - base, 68);
    status_check("status_after_double", 8'h00);

    // Reset in the middle of a write strobe
    cpu_write(5'($urandom_range(0, 31)), 8'($urandom_range(33, 126)));
    push_refresh();
    n = 0;
    while (!m_write && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("strobe_found", {31'h0, m_write}, 32'd1);
    repeat (4) @(negedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    check("reset_mid_strobe", {30'h0, m_write, m_read}, 32'd0);
    exp_q.delete();
    busy_q.delete();
    for (int i = 0; i < 32; i++) model_buf[i] = 8'h20;
    push_init();
    push_refresh();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    status_check("status_pwrup_again", 8'h03);
    wait_drain("drain_after_reset");
    status_check("status_final", 8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/lcd_text_sequencer.md
Name: lcd_text_sequencer

Overview:
- Autonomous Avalon-MM master that feeds the 16x2 character-LCD control slave directly downstream.
- Holds a 32-byte shadow character buffer that the CPU writes through a small slave port.
- Initialises the HD44780 controller, then refreshes the whole display whenever the buffer changes.
- Stretches each LCD access so that the combinational E strobe meets the controller's setup, pulse-width and hold times, and polls the busy flag between accesses.

Parameters:
- POWERUP_CYCLES, 750000, wait after reset before the first command (15 ms at 50 MHz).
- SETUP_CYCLES, 3, cycles that m_address/m_writedata are stable before the strobe.
- E_CYCLES, 12, cycles that m_read/m_write stay high (the E pulse width).
- HOLD_CYCLES, 3, cycles that address/data are held after the strobe drops.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- s_address  in  5  shadow buffer index: 0-15 line 1, 16-31 line 2.
- s_write  in  1  CPU write strobe; zero wait states.
- s_writedata  in  8  character code.
- s_read  in  1  CPU status read.
- s_readdata  out  8  status: {6'b0, dirty, busy}; registered, valid 1 cycle after s_read.
- m_address  out  2  to LCD slave: bit1 = RS, bit0 = RW.
- m_begintransfer  out  1  single-cycle pulse on the first strobe cycle.
- m_read  out  1  busy-flag read strobe.
- m_write  out  1  command/data write strobe.
- m_writedata  out  8  command or character.
- m_readdata  in  8  LCD data bus readback; bit7 = busy flag.

Behaviour:
- Reset values:
  - all m_* outputs and s_readdata are 0;
  - dirty = 1, so the display is refreshed after init;
  - the shadow buffer is filled with 0x20 (space);
  - the FSM enters PWRUP and the counters clear.
- Reset asserted mid-access drops m_read/m_write in the same reset assertion, with no partial hold; the full PWRUP and INIT sequence is repeated after reset.
- Access sub-FSM (used for every LCD access): ACC_SETUP (SETUP_CYCLES) -> ACC_STROBE (E_CYCLES) -> ACC_HOLD (HOLD_CYCLES) -> done.
  - m_address and m_writedata are constant across all three phases.
  - m_read/m_write are high only in ACC_STROBE.
  - For reads, m_readdata is sampled on the last ACC_STROBE cycle.
- Access codes: command write = 2'b00, busy read = 2'b01, data write = 2'b10.
- Every write is followed by POLL, a busy read repeated until bit7 = 0. Polling has no timeout.
- Main FSM states and transitions:
  - PWRUP: count POWERUP_CYCLES -> INIT.
  - INIT: issue commands 0x38, 0x0C, 0x01, 0x06 in order, each followed by POLL -> IDLE.
  - IDLE: if dirty, clear dirty and go to ADDR1; otherwise stay.
  - ADDR1: command 0x80 -> LINE1.
  - LINE1: data writes of buffer[0..15] -> ADDR2.
  - ADDR2: command 0xC0 -> LINE2.
  - LINE2: data writes of buffer[16..31] -> IDLE.
- Character index: 5-bit counter; it wraps from 15 to the ADDR2 step and from 31 back to IDLE.
- CPU writes:
  - Writes land in the buffer in the same cycle and set dirty.
  - A write during a refresh sets dirty again, so exactly one further full refresh follows. The in-flight refresh may show old or new data for that index.
  - A CPU write in the same cycle as IDLE clears dirty: set wins.
- Busy status (s_readdata bit0) is 1 in every state except IDLE.
- Only one of m_read/m_write is ever high; they are never asserted together.
- With the slave's strobe being read|write, every E pulse therefore lasts exactly E_CYCLES cycles.

Test Plan:
- Reset, POWERUP_CYCLES=20, m_readdata bit7 held 0 -> after 20 cycles, writes 0x38, 0x0C, 0x01, 0x06 with m_address = 00, each followed by one read with m_address = 01. Then 0x80, sixteen 0x20 bytes at 10, 0xC0, sixteen 0x20 bytes. Status reads 0x00 at the end.
- Check any single access -> m_writedata/m_address stable for 3+12+3 cycles; m_write high exactly 12 cycles; m_begintransfer high exactly 1 cycle, aligned with the first strobe cycle.
- Busy model holds bit7 = 1 for 3 reads after 0x01 -> exactly 4 reads are issued before 0x06 is sent.
- In IDLE, CPU writes 0x41 at s_address 17 -> refresh issues 0x80, 16 spaces, 0xC0, then 0x20 followed by 0x41 as the second line-2 byte.
- CPU writes during the LINE1 phase of a refresh -> dirty reads 1 mid-refresh, and a second complete refresh (34 writes) follows before IDLE.
- reset_n pulsed low during ACC_STROBE -> m_write drops immediately, and PWRUP restarts with the full init sequence.
